mano_icache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache between the Mano control path and main memory.
- Generates the `cache_hit` signal the sequencer waits on at T1, and supplies read data to the memory input of the bus.
- On a miss it runs a refill handshake with main memory, then reports a hit so the stalled fetch completes.
- Data and operand accesses use the same port, so one cache serves both fetch and execute cycles.

---
 rtl/mano_icache_pkg.sv | 18 +
 rtl/mano_icache_if.sv | 22 ++
 rtl/mano_icache_array.sv | 42 ++++
 rtl/mano_icache.sv | 142 ++++++++++++++
 tb/tb_mano_icache.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mano_icache_pkg.sv
// Shared types and defaults for the mano_icache direct-mapped cache.
package mano_icache_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IDX_W_DEF  = 4;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_FILL  = 2'd1,
    C_WRITE = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mano_icache_if.sv
// CPU-side request/response bus between the Mano control path and the cache.
interface mano_icache_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) ();
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cache_hit;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cache_hit
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cache_hit
    );
endinterface

// File: rtl/mano_icache_array.sv
// Valid/tag/data storage: async valid clear, combinational read, one sync write port.
module mano_icache_array #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int unsigned LINES = 2 ** IDX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (we)
            valid[wr_idx] <= 1'b1;
    end

    // Tag and data arrays are deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];
endmodule

// File: rtl/mano_icache.sv
// Direct-mapped write-through, no-write-allocate cache for the Mano control path.
// Optional hit/miss counters are enabled with MANO_ICACHE_STATS_EN.
module mano_icache
    import mano_icache_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned TAG_W  = ADDR_W - IDX_W
) (
    input  logic              mclk,
    input  logic              mrst,
    mano_icache_if.slave      cpu,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef MANO_ICACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              latch;
    logic              idle_hit, idle_miss;
    logic              we;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  cmp_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              line_match;

    // IDLE looks up the live address; FILL/WRITE look up the latched one.
    assign rd_idx     = (state == C_IDLE) ? cpu.cpu_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
    assign cmp_tag    = (state == C_IDLE) ? cpu.cpu_addr[ADDR_W-1:IDX_W] : addr_q[ADDR_W-1:IDX_W];
    assign line_match = rd_valid && (rd_tag == cmp_tag);

    mano_icache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (mclk),
        .rst      (mrst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (we),
        .wr_idx   (addr_q[IDX_W-1:0]),
        .wr_tag   (addr_q[ADDR_W-1:IDX_W]),
        .wr_data  (wr_data)
    );

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst)
            state <= C_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        cpu.cache_hit = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        latch         = 1'b0;
        idle_hit      = 1'b0;
        idle_miss     = 1'b0;
        we            = 1'b0;
        wr_data       = wdata_q;
        case (state)
            C_IDLE: begin
                if (cpu.cpu_wr) begin
                    latch    = 1'b1;
                    state_nx = C_WRITE;
                end else if (cpu.cpu_rd) begin
                    if (line_match) begin
                        cpu.cache_hit = 1'b1;
                        idle_hit      = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        idle_miss = 1'b1;
                        state_nx  = C_FILL;
                    end
                end
            end
            C_FILL: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    we       = 1'b1;
                    wr_data  = mem_rdata;
                    state_nx = C_IDLE;
                end
            end
            C_WRITE: begin
                mem_wr = 1'b1;
                if (mem_ack) begin
                    cpu.cache_hit = 1'b1;
                    we            = line_match;
                    state_nx      = C_IDLE;
                end
            end
            default: state_nx = C_IDLE;
        endcase
    end

    assign cpu.cpu_rdata = idle_hit ? rd_data : '0;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (latch) begin
            addr_q  <= cpu.cpu_addr;
            wdata_q <= cpu.cpu_wdata;
        end
    end

`ifdef MANO_ICACHE_STATS_EN
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit)
                hit_cnt <= sat_inc(hit_cnt);
            if (idle_miss)
                miss_cnt <= sat_inc(miss_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_mano_icache.sv
// Directed self-checking bench for mano_icache (counters checked when MANO_ICACHE_STATS_EN is set).
module tb_mano_icache;
    logic        clk;
    logic        rst;
    logic        mem_rd, mem_wr, mem_ack;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    int          tests, fails;
    int          exp_hit, exp_miss;
`ifdef MANO_ICACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    mano_icache_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    mano_icache #(
        .ADDR_W (12),
        .DATA_W (16),
        .IDX_W  (4)
    ) dut (
        .mclk      (clk),
        .mrst      (rst),
        .cpu       (bus),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef MANO_ICACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef MANO_ICACHE_STATS_EN
        chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
`endif
    endtask

    // Read that misses: lat idle FILL cycles before the ack cycle.
    task automatic read_miss(input logic [11:0] a, input logic [15:0] d, input int lat, input bit drop);
        @(negedge clk);
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = a;
        #1 chk("miss_req_hit", 32'(bus.cache_hit), 32'h0);
        chk("miss_req_mem_rd", 32'(mem_rd), 32'h0);
        exp_miss++;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            bus.cpu_addr = a ^ 12'h0F0;
            if (drop && i == 0) bus.cpu_rd = 1'b0;
            #1 chk("fill_mem_rd", 32'(mem_rd), 32'h1);
            chk("fill_mem_addr", 32'(mem_addr), 32'(a));
            chk("fill_mem_wr", 32'(mem_wr), 32'h0);
            chk("fill_hit", 32'(bus.cache_hit), 32'h0);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = d;
        #1 chk("ack_mem_rd", 32'(mem_rd), 32'h1);
        chk("ack_mem_addr", 32'(mem_addr), 32'(a));
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0; bus.cpu_addr = a;
        #1 chk("post_fill_mem_rd", 32'(mem_rd), 32'h0);
        if (drop) begin
            chk("dropped_hit", 32'(bus.cache_hit), 32'h0);
        end else begin
            chk("post_fill_hit", 32'(bus.cache_hit), 32'h1);
            chk("post_fill_rdata", 32'(bus.cpu_rdata), 32'(d));
            exp_hit++;
        end
    endtask

    task automatic read_hit(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = a;
        #1 chk("hit_hit", 32'(bus.cache_hit), 32'h1);
        chk("hit_rdata", 32'(bus.cpu_rdata), 32'(d));
        chk("hit_mem_rd", 32'(mem_rd), 32'h0);
        exp_hit++;
    endtask

    task automatic write(input logic [11:0] a, input logic [15:0] d, input int lat, input bit also_rd);
        @(negedge clk);
        bus.cpu_wr = 1'b1; bus.cpu_rd = also_rd; bus.cpu_addr = a; bus.cpu_wdata = d;
        #1 chk("wr_req_hit", 32'(bus.cache_hit), 32'h0);
        chk("wr_req_mem_wr", 32'(mem_wr), 32'h0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            bus.cpu_addr = ~a; bus.cpu_wdata = ~d;
            #1 chk("wr_mem_wr", 32'(mem_wr), 32'h1);
            chk("wr_mem_rd", 32'(mem_rd), 32'h0);
            chk("wr_mem_addr", 32'(mem_addr), 32'(a));
            chk("wr_mem_wdata", 32'(mem_wdata), 32'(d));
            chk("wr_wait_hit", 32'(bus.cache_hit), 32'h0);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1 chk("wr_ack_hit", 32'(bus.cache_hit), 32'h1);
        chk("wr_ack_mem_wr", 32'(mem_wr), 32'h1);
        chk("wr_ack_mem_wdata", 32'(mem_wdata), 32'(d));
        @(negedge clk);
        mem_ack = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        #1 chk("wr_done_mem_wr", 32'(mem_wr), 32'h0);
        chk("wr_done_hit", 32'(bus.cache_hit), 32'h0);
    endtask

    initial begin
        tests = 0; fails = 0; exp_hit = 0; exp_miss = 0;
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 12'h0; bus.cpu_wdata = 16'h0;
        #1 rst = 1'b1;
        #2;
        chk("rst_hit", 32'(bus.cache_hit), 32'h0);
        chk("rst_mem_rd", 32'(mem_rd), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk_stats();
        @(negedge clk);
        rst = 1'b0;

        read_miss(12'h010, 16'h7123, 1, 1'b0);
        read_hit(12'h010, 16'h7123);
        read_hit(12'h010, 16'h7123);
        read_miss(12'h020, 16'h0AAA, 1, 1'b0);
        read_miss(12'h010, 16'h7123, 2, 1'b1);
        read_miss(12'h020, 16'h0AAA, 0, 1'b0);

        write(12'h020, 16'hBEEF, 1, 1'b0);
        read_hit(12'h020, 16'hBEEF);

        write(12'h3F5, 16'h1234, 0, 1'b0);
        read_miss(12'h3F5, 16'h1234, 1, 1'b0);

        write(12'h020, 16'hCAFE, 1, 1'b1);
        read_hit(12'h020, 16'hCAFE);

        @(negedge clk);
        bus.cpu_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1 chk("idle_ack_hit", 32'(bus.cache_hit), 32'h0);
        chk("idle_ack_mem_rd", 32'(mem_rd), 32'h0);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0;
        read_hit(12'h020, 16'hCAFE);
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        #1 chk_stats();

        @(negedge clk);
        bus.cpu_rd = 1'b1; bus.cpu_addr = 12'h7F0;
        #1 chk("rstfill_req_hit", 32'(bus.cache_hit), 32'h0);
        exp_miss++;
        @(negedge clk);
        #1 chk("rstfill_mem_rd1", 32'(mem_rd), 32'h1);
        @(negedge clk);
        #1 chk("rstfill_mem_rd2", 32'(mem_rd), 32'h1);
        rst = 1'b1;
        #1 chk("rstfill_mem_rd_drop", 32'(mem_rd), 32'h0);
        chk("rstfill_hit", 32'(bus.cache_hit), 32'h0);
        exp_hit = 0; exp_miss = 0;
        chk_stats();
        @(negedge clk);
        rst = 1'b0; bus.cpu_rd = 1'b0;
        read_miss(12'h3F5, 16'h1234, 1, 1'b0);
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        #1 chk_stats();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
